// File: rtl/weight_load_sequencer_if.sv
// Command, host byte stream and weight-memory bus of the weight load sequencer.
// The master modport belongs to the control/host side, which issues commands and
// supplies bytes. The slave modport belongs to the sequencer.
interface weight_load_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_len;
    logic              abort;

    logic [DATA_W-1:0] host_data;
    logic              host_valid;
    logic              host_ready;

    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_load;
    logic [ADDR_W-1:0] mem_addr;

    logic              busy;
    logic              done;
    logic              err;
    logic              weights_valid;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, abort,
        output host_data, host_valid,
        input  cmd_ready, host_ready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_load, mem_addr,
        input  busy, done, err, weights_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, abort,
        input  host_data, host_valid,
        output cmd_ready, host_ready,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_load, mem_addr,
        output busy, done, err, weights_valid
    );
endinterface

// File: rtl/weight_load_sequencer.sv
// Weight load sequencer: executes range-checked "fetch" commands (host bytes
// written into a contiguous span of weight memory) and "load" commands (one
// tile-load strobe, then a settle cycle before the tile is reported valid).
// Optional feature macro WLS_HOST_TIMEOUT_EN: abandons a fetch with an error
// pulse after TIMEOUT consecutive cycles without a host byte.
module weight_load_sequencer #(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 8,
    parameter int ADDR_W    = 5,
    parameter int TILE      = 4,
    parameter int TIMEOUT   = 255
) (
    input logic                    clk,
    input logic                    reset,
    weight_load_sequencer_if.slave bus
);

    // The extra bit keeps start+length sums from wrapping.
    localparam int SUM_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SETTLE,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [3:0]        remaining, remaining_next;
    logic              op_load, op_load_next;

    logic              wr_en_q, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_next;
    logic [DATA_W-1:0] wr_data_q, wr_data_next;
    logic              load_q, load_next;
    logic [ADDR_W-1:0] load_addr_q, load_addr_next;
    logic              done_q, done_next;
    logic              err_q, err_next;
    logic              wv_q, wv_next;

    logic              cmd_hs;
    logic              host_hs;
    logic [SUM_W-1:0]  fetch_end;
    logic [SUM_W-1:0]  load_end;
    logic              fetch_illegal;
    logic              load_illegal;

`ifdef WLS_HOST_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer, timer_next;
    logic             timed_out;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    assign cmd_hs  = bus.cmd_valid && (state == IDLE);
    assign host_hs = bus.host_valid && (state == FETCH);

    assign fetch_end     = {1'b0, bus.cmd_addr} + SUM_W'(bus.cmd_len);
    assign load_end      = {1'b0, bus.cmd_addr} + SUM_W'(TILE);
    assign fetch_illegal = (bus.cmd_len == 4'd0) || (fetch_end > SUM_W'(NUM_WORDS));
    assign load_illegal  = (load_end > SUM_W'(NUM_WORDS));

    assign bus.cmd_ready     = (state == IDLE);
    assign bus.host_ready    = (state == FETCH);
    assign bus.busy          = (state != IDLE);
    assign bus.mem_wr_en     = wr_en_q;
    assign bus.mem_wr_addr   = wr_addr_q;
    assign bus.mem_wr_data   = wr_data_q;
    assign bus.mem_load      = load_q;
    assign bus.mem_addr      = load_addr_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.weights_valid = wv_q;

`ifdef WLS_HOST_TIMEOUT_EN
    // Count consecutive host-idle FETCH cycles; anything else restarts the count.
    always_comb begin
        timer_next = '0;
        if (state == FETCH && !host_hs) begin
            timer_next = timer + TMR_W'(1);
        end
    end

    assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

    // Host-idle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else begin
            timer <= timer_next;
        end
    end
`endif

    // Next state plus the next value of every registered output.
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        remaining_next = remaining;
        op_load_next   = op_load;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_q;
        wr_data_next   = wr_data_q;
        load_next      = 1'b0;
        load_addr_next = load_addr_q;
        done_next      = 1'b0;
        err_next       = 1'b0;
        wv_next        = wv_q;

        unique case (state)
            IDLE: begin
                if (cmd_hs) begin
                    wv_next = 1'b0;
                    if (!bus.cmd_op) begin
                        if (fetch_illegal) begin
                            err_next = 1'b1;
                        end else begin
                            ptr_next       = bus.cmd_addr;
                            remaining_next = bus.cmd_len;
                            op_load_next   = 1'b0;
                            state_next     = FETCH;
                        end
                    end else begin
                        if (load_illegal) begin
                            err_next = 1'b1;
                        end else begin
                            load_next      = 1'b1;
                            load_addr_next = bus.cmd_addr;
                            op_load_next   = 1'b1;
                            state_next     = LOAD;
                        end
                    end
                end
            end

            FETCH: begin
                if (bus.abort) begin
                    // Abort wins over a same-cycle byte, which is dropped.
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (host_hs) begin
                    wr_en_next     = 1'b1;
                    wr_addr_next   = ptr;
                    wr_data_next   = bus.host_data;
                    ptr_next       = ptr + ADDR_W'(1);
                    remaining_next = remaining - 4'd1;
                    if (remaining == 4'd1) begin
                        // The final write and the done pulse share a cycle.
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
`ifdef WLS_HOST_TIMEOUT_EN
                end else if (timed_out) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
`endif
                end
            end

            LOAD: begin
                state_next = SETTLE;
            end

            SETTLE: begin
                state_next = DONE;
            end

            DONE: begin
                // A load reports completion only once the memory outputs have settled.
                if (op_load) begin
                    done_next = 1'b1;
                    wv_next   = 1'b1;
                end
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state: FSM state, write pointer, words left and current opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            op_load   <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            remaining <= remaining_next;
            op_load   <= op_load_next;
        end
    end

    // Registered memory-side and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            load_q      <= 1'b0;
            load_addr_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wv_q        <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_next;
            wr_addr_q   <= wr_addr_next;
            wr_data_q   <= wr_data_next;
            load_q      <= load_next;
            load_addr_q <= load_addr_next;
            done_q      <= done_next;
            err_q       <= err_next;
            wv_q        <= wv_next;
        end
    end

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Testbench for weight_load_sequencer: each scenario task drives commands and
// host bytes and compares the outputs cycle by cycle with expectations derived
// from command legality, byte order and the documented latencies.
module tb_weight_load_sequencer;

    localparam int DATA_W      = 8;
    localparam int NUM_WORDS   = 8;
    localparam int ADDR_W      = 5;
    localparam int TILE        = 4;
    localparam int TIMEOUT_CYC = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    weight_load_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    weight_load_sequencer #(
        .DATA_W   (DATA_W),
        .NUM_WORDS(NUM_WORDS),
        .ADDR_W   (ADDR_W),
        .TILE     (TILE),
        .TIMEOUT  (TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.mem_wr_en, bus.mem_load, bus.done, bus.err, bus.weights_valid,
             bus.busy, bus.host_ready, bus.cmd_ready} !== 8'b0000_0001) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 00000001",
                     {bus.mem_wr_en, bus.mem_load, bus.done, bus.err, bus.weights_valid,
                      bus.busy, bus.host_ready, bus.cmd_ready});
        end
        checks++;
        if ({bus.mem_wr_addr, bus.mem_wr_data, bus.mem_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_buses got %h want 0",
                     {bus.mem_wr_addr, bus.mem_wr_data, bus.mem_addr});
        end
        reset = 1'b0;
        tick();
    endtask

    // One fetch command. Bit i of valid_pat is host_valid in the i-th offered slot
    // (all ones beyond slot 31); abort_idx picks the byte whose handshake carries abort.
    task automatic test_fetch(input int addr, input int len, input logic [31:0] valid_pat,
                              input bit pat_data, input int abort_idx);
        int         accepted;
        int         slot;
        bit         legal;
        bit         hv;
        bit         ab;
        logic [7:0] byte_q;
        legal = (len != 0) && (addr + len <= NUM_WORDS);

        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_cmd_ready got %b want 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_addr  = ADDR_W'(addr);
        bus.cmd_len   = 4'(len);
        tick();
        bus.cmd_valid = 1'b0;

        if (!legal) begin
            checks++;
            if ({bus.err, bus.mem_wr_en, bus.mem_load, bus.done, bus.weights_valid, bus.cmd_ready}
                !== 6'b100001) begin
                errors++;
                $display("[TB] FAIL fetch_illegal a=%0d l=%0d got %b want 100001", addr, len,
                         {bus.err, bus.mem_wr_en, bus.mem_load, bus.done, bus.weights_valid, bus.cmd_ready});
            end
            tick();
            checks++;
            if (bus.err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL fetch_illegal_err_pulse got %b want 0", bus.err);
            end
            return;
        end

        checks++;
        if ({bus.busy, bus.host_ready, bus.cmd_ready, bus.err, bus.weights_valid, bus.mem_wr_en}
            !== 6'b110000) begin
            errors++;
            $display("[TB] FAIL fetch_accept got %b want 110000",
                     {bus.busy, bus.host_ready, bus.cmd_ready, bus.err, bus.weights_valid, bus.mem_wr_en});
        end

        accepted = 0;
        slot     = 0;
        while (accepted < len && slot < 200) begin
            hv     = (slot < 32) ? valid_pat[slot] : 1'b1;
            ab     = hv && (accepted == abort_idx);
            byte_q = pat_data ? 8'(8'h11 * (accepted + 1)) : 8'($urandom);
            bus.host_valid = hv;
            bus.host_data  = byte_q;
            bus.abort      = ab;
            tick();
            bus.host_valid = 1'b0;
            bus.abort      = 1'b0;
            slot++;
            if (ab) begin
                checks++;
                if ({bus.err, bus.mem_wr_en, bus.done, bus.cmd_ready, bus.busy} !== 5'b10010) begin
                    errors++;
                    $display("[TB] FAIL abort_response got %b want 10010",
                             {bus.err, bus.mem_wr_en, bus.done, bus.cmd_ready, bus.busy});
                end
                tick();
                checks++;
                if ({bus.err, bus.mem_wr_en} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL abort_after got %b want 00", {bus.err, bus.mem_wr_en});
                end
                return;
            end
            if (hv) begin
                checks++;
                if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data} !==
                    {1'b1, ADDR_W'(addr + accepted), byte_q}) begin
                    errors++;
                    $display("[TB] FAIL fetch_write got en=%b a=%0d d=%h want en=1 a=%0d d=%h",
                             bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, addr + accepted, byte_q);
                end
                accepted++;
                checks++;
                if (bus.done !== (accepted == len)) begin
                    errors++;
                    $display("[TB] FAIL fetch_done got %b want %b", bus.done, accepted == len);
                end
            end else begin
                checks++;
                if ({bus.mem_wr_en, bus.done, bus.err, bus.host_ready} !== 4'b0001) begin
                    errors++;
                    $display("[TB] FAIL fetch_gap got %b want 0001",
                             {bus.mem_wr_en, bus.done, bus.err, bus.host_ready});
                end
            end
        end

        checks++;
        if (accepted != len) begin
            errors++;
            $display("[TB] FAIL fetch_budget got %0d bytes want %0d", accepted, len);
        end
        checks++;
        if ({bus.busy, bus.cmd_ready, bus.host_ready} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL fetch_done_state got %b want 100",
                     {bus.busy, bus.cmd_ready, bus.host_ready});
        end
        tick();
        checks++;
        if ({bus.busy, bus.cmd_ready, bus.done, bus.mem_wr_en, bus.err} !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL fetch_end got %b want 01000",
                     {bus.busy, bus.cmd_ready, bus.done, bus.mem_wr_en, bus.err});
        end
    endtask

    task automatic test_load(input int addr);
        bit legal;
        legal = (addr + TILE <= NUM_WORDS);

        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_cmd_ready got %b want 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b1;
        bus.cmd_addr  = ADDR_W'(addr);
        bus.cmd_len   = 4'($urandom);
        tick();
        bus.cmd_valid = 1'b0;

        if (!legal) begin
            checks++;
            if ({bus.err, bus.mem_load, bus.mem_wr_en, bus.weights_valid, bus.cmd_ready}
                !== 5'b10001) begin
                errors++;
                $display("[TB] FAIL load_illegal a=%0d got %b want 10001", addr,
                         {bus.err, bus.mem_load, bus.mem_wr_en, bus.weights_valid, bus.cmd_ready});
            end
            tick();
            checks++;
            if (bus.err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL load_illegal_err_pulse got %b want 0", bus.err);
            end
            return;
        end

        checks++;
        if ({bus.mem_load, bus.mem_addr, bus.mem_wr_en, bus.weights_valid, bus.busy, bus.cmd_ready}
            !== {1'b1, ADDR_W'(addr), 4'b0010}) begin
            errors++;
            $display("[TB] FAIL load_strobe got ld=%b a=%0d we=%b wv=%b busy=%b rdy=%b want ld=1 a=%0d 0 0 1 0",
                     bus.mem_load, bus.mem_addr, bus.mem_wr_en, bus.weights_valid, bus.busy,
                     bus.cmd_ready, addr);
        end
        tick();
        checks++;
        if ({bus.mem_load, bus.done, bus.weights_valid, bus.busy} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL load_settle got %b want 0001",
                     {bus.mem_load, bus.done, bus.weights_valid, bus.busy});
        end
        tick();
        checks++;
        if ({bus.done, bus.weights_valid, bus.cmd_ready, bus.busy} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL load_done_state got %b want 0001",
                     {bus.done, bus.weights_valid, bus.cmd_ready, bus.busy});
        end
        tick();
        checks++;
        if ({bus.done, bus.weights_valid, bus.cmd_ready, bus.busy} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL load_done_pulse got %b want 1110",
                     {bus.done, bus.weights_valid, bus.cmd_ready, bus.busy});
        end
        tick();
        checks++;
        if ({bus.done, bus.weights_valid} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL load_wv_hold got %b want 01", {bus.done, bus.weights_valid});
        end
    endtask

    task automatic test_abort_idle();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.err, bus.cmd_ready, bus.busy} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL abort_idle got %b want 010", {bus.err, bus.cmd_ready, bus.busy});
        end
    endtask

    task automatic test_reset_mid_fetch();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_addr  = 5'd1;
        bus.cmd_len   = 4'd5;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.host_valid = 1'b1;
            bus.host_data  = 8'($urandom);
            tick();
            checks++;
            if ({bus.mem_wr_en, bus.mem_wr_addr} !== {1'b1, 5'(1 + k)}) begin
                errors++;
                $display("[TB] FAIL midreset_write got en=%b a=%0d want en=1 a=%0d",
                         bus.mem_wr_en, bus.mem_wr_addr, 1 + k);
            end
        end
        bus.host_valid = 1'b1;
        reset          = 1'b1;
        tick();
        checks++;
        if ({bus.mem_wr_en, bus.mem_load, bus.done, bus.err, bus.weights_valid,
             bus.busy, bus.host_ready, bus.cmd_ready} !== 8'b0000_0001) begin
            errors++;
            $display("[TB] FAIL midreset_flags got %b want 00000001",
                     {bus.mem_wr_en, bus.mem_load, bus.done, bus.err, bus.weights_valid,
                      bus.busy, bus.host_ready, bus.cmd_ready});
        end
        checks++;
        if ({bus.mem_wr_addr, bus.mem_wr_data, bus.mem_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_buses got %h want 0",
                     {bus.mem_wr_addr, bus.mem_wr_data, bus.mem_addr});
        end
        reset          = 1'b0;
        bus.host_valid = 1'b0;
        tick();
        test_load(4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            test_fetch(i, 4, 32'hFFFF_FFFF, 1'b0, -1);
            test_load(i);
        end
    endtask

    task automatic test_random();
        int op;
        int addr;
        int len;
        int ab;
        for (int i = 0; i < 40; i++) begin
            op   = int'($urandom_range(0, 1));
            addr = int'($urandom_range(0, 9));
            len  = int'($urandom_range(0, 9));
            ab   = -1;
            if (len > 0 && $urandom_range(0, 3) == 0) begin
                ab = int'($urandom_range(0, len - 1));
            end
            if (op == 0) begin
                test_fetch(addr, len, $urandom | 32'h1111_1111, 1'b0, ab);
            end else begin
                test_load(addr);
            end
        end
    endtask

`ifdef WLS_HOST_TIMEOUT_EN
    task automatic test_timeout();
        // Host never answers: the error comes TIMEOUT cycles after entering FETCH.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_addr  = 5'd0;
        bus.cmd_len   = 4'd2;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            tick();
            checks++;
            if ({bus.err, bus.cmd_ready} !== {k == TIMEOUT_CYC, k == TIMEOUT_CYC}) begin
                errors++;
                $display("[TB] FAIL timeout_cycle%0d got %b want %b", k,
                         {bus.err, bus.cmd_ready}, {k == TIMEOUT_CYC, k == TIMEOUT_CYC});
            end
        end
        tick();
        // A byte arriving on the last allowed idle cycle beats the timeout.
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k < TIMEOUT_CYC; k++) begin
            tick();
        end
        bus.host_valid = 1'b1;
        bus.host_data  = 8'hA5;
        tick();
        bus.host_valid = 1'b0;
        checks++;
        if ({bus.err, bus.mem_wr_en, bus.mem_wr_data, bus.busy} !== {2'b01, 8'hA5, 1'b1}) begin
            errors++;
            $display("[TB] FAIL timeout_race got err=%b we=%b d=%h busy=%b want 0 1 a5 1",
                     bus.err, bus.mem_wr_en, bus.mem_wr_data, bus.busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask
`endif

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.abort      = 1'b0;
        bus.host_data  = '0;
        bus.host_valid = 1'b0;

        test_reset();
        test_fetch(0, 4, 32'hFFFF_FFFF, 1'b1, -1);
        test_fetch(2, 3, 32'h0000_0019, 1'b0, -1);
        test_load(4);
        test_fetch(6, 3, 32'hFFFF_FFFF, 1'b0, -1);
        test_fetch(0, 0, 32'hFFFF_FFFF, 1'b0, -1);
        test_load(5);
        test_fetch(0, 4, 32'hFFFF_FFFF, 1'b0, 2);
        test_load(0);
        test_abort_idle();
        test_fetch(0, 8, $urandom | 32'h1111_1111, 1'b0, -1);
        test_back_to_back();
        test_random();
        test_reset_mid_fetch();
`ifdef WLS_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the scenarios completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule
